// File: rtl/cntseq_pkg.sv
// ============================================================================
// Module  : cntseq_pkg
// Brief   : Shared types and defaults for the count job sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cntseq_pkg;

  localparam int CNTSEQ_CW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    GAP   = 2'd3
  } cntseq_state_t;

endpackage

`default_nettype wire

// File: rtl/cntseq_fifo.sv
// ============================================================================
// Module  : cntseq_fifo
// Brief   : DEPTH x CW job FIFO with occupancy count; head is always visible.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cntseq_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [CW-1:0]            push_data,
  input  logic                     pop,
  output logic [CW-1:0]            pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0] mem_q [DEPTH];
  logic [CW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/count_job_sequencer.sv
// ============================================================================
// Module  : count_job_sequencer
// Brief   : Buffers count targets and drives a down-counter one job at a time
//           (load pulse, count_en until done or watchdog, one gap cycle).
//           Define CNTSEQ_JOB_CNT_EN to add the jobs_done completion counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_job_sequencer
  import cntseq_pkg::*;
#(
  parameter int CW     = CNTSEQ_CW,
  parameter int DEPTH  = 4,
  parameter int WD_MAX = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CW-1:0]          in_value,
  output logic                   ctr_load,
  output logic [CW-1:0]          ctr_count_to,
  output logic                   ctr_count_en,
  input  logic                   ctr_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   wd_err
`ifdef CNTSEQ_JOB_CNT_EN
  ,
  output logic [7:0]             jobs_done
`endif
);

  localparam int WDW = $clog2(WD_MAX);

  cntseq_state_t state_q, state_d;
  logic          ctr_load_q, ctr_load_d;
  logic [CW-1:0] ctr_count_to_q, ctr_count_to_d;
  logic          ctr_count_en_q, ctr_count_en_d;
  logic          busy_q, busy_d;
  logic          wd_err_q, wd_err_d;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
`ifdef CNTSEQ_JOB_CNT_EN
  logic [7:0]    jobs_done_q, jobs_done_d;
`endif

  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CW-1:0] fifo_head;

  // Gated by reset so the source sees no acceptance while reset is held.
  assign in_ready  = !fifo_full && !reset;
  assign fifo_push = in_valid && in_ready;

  cntseq_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(in_value),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  always_comb begin
    state_d        = state_q;
    ctr_load_d     = 1'b0;
    ctr_count_en_d = 1'b0;
    ctr_count_to_d = ctr_count_to_q;
    wd_cnt_d       = wd_cnt_q;
    wd_err_d       = wd_err_q;
    fifo_pop       = 1'b0;
`ifdef CNTSEQ_JOB_CNT_EN
    jobs_done_d    = jobs_done_q;
`endif
    case (state_q)
      IDLE: begin
        // Outputs are registered, so the load is set up one state early.
        if (!fifo_empty) begin
          state_d        = LOAD;
          ctr_load_d     = 1'b1;
          ctr_count_to_d = fifo_head;
          fifo_pop       = 1'b1;
        end
      end
      LOAD: begin
        state_d        = COUNT;
        ctr_count_en_d = 1'b1;
        wd_cnt_d       = '0;
      end
      COUNT: begin
        if (ctr_done) begin
          state_d = GAP;
`ifdef CNTSEQ_JOB_CNT_EN
          jobs_done_d = jobs_done_q + 8'd1;
`endif
        end else if (wd_cnt_q == WDW'(WD_MAX - 1)) begin
          state_d  = GAP;
          wd_err_d = 1'b1;
        end else begin
          ctr_count_en_d = 1'b1;
          wd_cnt_d       = wd_cnt_q + WDW'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ctr_load_q     <= 1'b0;
      ctr_count_to_q <= '0;
      ctr_count_en_q <= 1'b0;
      busy_q         <= 1'b0;
      wd_err_q       <= 1'b0;
      wd_cnt_q       <= '0;
`ifdef CNTSEQ_JOB_CNT_EN
      jobs_done_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ctr_load_q     <= ctr_load_d;
      ctr_count_to_q <= ctr_count_to_d;
      ctr_count_en_q <= ctr_count_en_d;
      busy_q         <= busy_d;
      wd_err_q       <= wd_err_d;
      wd_cnt_q       <= wd_cnt_d;
`ifdef CNTSEQ_JOB_CNT_EN
      jobs_done_q    <= jobs_done_d;
`endif
    end
  end

  assign ctr_load     = ctr_load_q;
  assign ctr_count_to = ctr_count_to_q;
  assign ctr_count_en = ctr_count_en_q;
  assign busy         = busy_q;
  assign wd_err       = wd_err_q;
`ifdef CNTSEQ_JOB_CNT_EN
  assign jobs_done    = jobs_done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_job_sequencer.sv
// ============================================================================
// Module  : tb_count_job_sequencer
// Brief   : Directed self-checking bench with a behavioural down-counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_job_sequencer;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, ctr_load, ctr_count_en, ctr_done;
  logic       busy, wd_err, hold_done;
  logic [2:0] in_value, ctr_count_to, m_count;
  logic [2:0] level;
  int         total = 0;
  int         bad   = 0;
`ifdef CNTSEQ_JOB_CNT_EN
  logic [7:0] jobs_done;
  int         exp_jobs = 0;
`endif

  always #5 clk = ~clk;

  count_job_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .ctr_load    (ctr_load),
    .ctr_count_to(ctr_count_to),
    .ctr_count_en(ctr_count_en),
    .ctr_done    (ctr_done),
    .busy        (busy),
    .level       (level),
    .wd_err      (wd_err)
`ifdef CNTSEQ_JOB_CNT_EN
    ,
    .jobs_done   (jobs_done)
`endif
  );

  // Behavioural 3-bit down-counter; hold_done lets a test stall it.
  always @(posedge clk) begin
    if (reset) m_count <= 3'd0;
    else if (ctr_load) m_count <= ctr_count_to;
    else if (ctr_count_en && m_count != 3'd0) m_count <= m_count - 3'd1;
  end
  assign ctr_done = (m_count == 3'd0) && !hold_done;

  task automatic check_jobs(input string name);
`ifdef CNTSEQ_JOB_CNT_EN
    total++;
    if (jobs_done !== 8'(exp_jobs)) begin
      bad++;
      $display("FAIL %s_jobs_done: got %0d expected %0d", name, jobs_done, exp_jobs);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_value = 3'd5; hold_done = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, ctr_load, ctr_count_en, busy, wd_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {in_ready, ctr_load, ctr_count_en, busy, wd_err});
    end
    total++;
    if (level !== 3'd0 || ctr_count_to !== 3'd0) begin
      bad++;
      $display("FAIL reset_level: got level=%0d count_to=%0d expected 0/0", level, ctr_count_to);
    end
    check_jobs("reset");
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n = 0;
    in_valid = 1'b1; in_value = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (level !== 3'd1) begin
      bad++; $display("FAIL single_level: got %0d expected 1", level);
    end
    @(negedge clk);
    total++;
    if (ctr_load !== 1'b1 || ctr_count_to !== 3'd7 || busy !== 1'b1 || level !== 3'd0) begin
      bad++;
      $display("FAIL single_load: got load=%b to=%0d busy=%b level=%0d expected 1/7/1/0",
               ctr_load, ctr_count_to, busy, level);
    end
    @(negedge clk);
    while (ctr_count_en === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== 8) begin
      bad++; $display("FAIL single_count_cycles: got %0d expected 8", n);
    end
    total++;
    if (busy !== 1'b1 || ctr_load !== 1'b0) begin
      bad++; $display("FAIL single_gap: got busy=%b load=%b expected 1/0", busy, ctr_load);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ctr_count_to !== 3'd7) begin
      bad++; $display("FAIL single_idle: got busy=%b to=%0d expected 0/7", busy, ctr_count_to);
    end
`ifdef CNTSEQ_JOB_CNT_EN
    exp_jobs++;
`endif
    check_jobs("single");
  endtask

  task automatic test_back_to_back();
    logic [2:0] vals [4] = '{3'd3, 3'd5, 3'd4, 3'd6};
    int got = 0;
    logic overlap = 1'b0;
    logic order_err = 1'b0;
    in_valid = 1'b1; in_value = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_value = vals[i];
      @(negedge clk);
    end
    in_value = 3'd1;
    total++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_full: got level=%0d ready=%b expected 4/0", level, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (level !== 3'd4 || ctr_count_en !== 1'b1) begin
      bad++; $display("FAIL b2b_no_overflow: got level=%0d en=%b expected 4/1", level, ctr_count_en);
    end
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (ctr_load === 1'b1 && ctr_count_en === 1'b1) overlap = 1'b1;
      if (ctr_load === 1'b1) begin
        if (got >= 4 || ctr_count_to !== vals[got]) order_err = 1'b1;
        got++;
      end
      if (got >= 4 && busy === 1'b0) break;
    end
    total++;
    if (got !== 4 || order_err !== 1'b0) begin
      bad++; $display("FAIL b2b_load_order: got loads=%0d order_err=%b expected 4/0", got, order_err);
    end
    total++;
    if (overlap !== 1'b0 || level !== 3'd0) begin
      bad++; $display("FAIL b2b_overlap: got overlap=%b level=%0d expected 0/0", overlap, level);
    end
`ifdef CNTSEQ_JOB_CNT_EN
    exp_jobs += 5;
`endif
    check_jobs("b2b");
  endtask

  task automatic test_zero();
    in_valid = 1'b1; in_value = 3'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (ctr_load !== 1'b1 || ctr_count_to !== 3'd0) begin
      bad++; $display("FAIL zero_load: got load=%b to=%0d expected 1/0", ctr_load, ctr_count_to);
    end
    @(negedge clk);
    total++;
    if (ctr_count_en !== 1'b1) begin
      bad++; $display("FAIL zero_count: got en=%b expected 1", ctr_count_en);
    end
    @(negedge clk);
    total++;
    if (ctr_count_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL zero_gap: got en=%b busy=%b expected 0/1", ctr_count_en, busy);
    end
    @(negedge clk);
`ifdef CNTSEQ_JOB_CNT_EN
    exp_jobs++;
`endif
    check_jobs("zero");
  endtask

  task automatic test_watchdog();
    int n = 0;
    hold_done = 1'b1;
    in_valid = 1'b1; in_value = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    while (ctr_count_en === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    hold_done = 1'b0;
    total++;
    if (n !== 10 || wd_err !== 1'b1) begin
      bad++; $display("FAIL wd_trip: got cycles=%0d wd_err=%b expected 10/1", n, wd_err);
    end
    check_jobs("wd");
    @(negedge clk);
    in_valid = 1'b1; in_value = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (ctr_load !== 1'b1 || ctr_count_to !== 3'd1 || wd_err !== 1'b1) begin
      bad++;
      $display("FAIL wd_next_job: got load=%b to=%0d wd_err=%b expected 1/1/1",
               ctr_load, ctr_count_to, wd_err);
    end
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL wd_next_done: got busy=%b expected 0", busy);
    end
`ifdef CNTSEQ_JOB_CNT_EN
    exp_jobs++;
`endif
    check_jobs("wd_next");
  endtask

  task automatic test_reset_mid();
    logic saw_load = 1'b0;
    in_valid = 1'b1; in_value = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_value = 3'd2;
    @(negedge clk);
    in_value = 3'd3;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (level !== 3'd2 || ctr_count_en !== 1'b1) begin
      bad++; $display("FAIL rst_mid_setup: got level=%0d en=%b expected 2/1", level, ctr_count_en);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({ctr_count_en, busy, in_ready, ctr_load, wd_err} !== 5'b0 || level !== 3'd0) begin
      bad++;
      $display("FAIL rst_mid_clear: got flags=%b level=%0d expected 00000/0",
               {ctr_count_en, busy, in_ready, ctr_load, wd_err}, level);
    end
`ifdef CNTSEQ_JOB_CNT_EN
    exp_jobs = 0;
`endif
    check_jobs("rst_mid");
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ctr_load !== 1'b0 || busy !== 1'b0) saw_load = 1'b1;
    end
    total++;
    if (saw_load !== 1'b0 || level !== 3'd0) begin
      bad++; $display("FAIL rst_mid_no_load: got activity=%b level=%0d expected 0/0", saw_load, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_watchdog();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
